// File: rtl/ifetch_queue_if.sv
// Read channel between the fetch queue (master) and instruction memory (slave).
// One read is outstanding at a time; the request is held until the response strobe.
interface ifetch_queue_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_resp,
    input  imem_rdata
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_resp,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_queue.sv
// Fetch front-end: issues single outstanding I-memory reads, tags each word with its PC
// and buffers {pc, word} pairs in a DEPTH-entry FIFO drained by the fetch stage.
//
// state  | meaning
// IDLE   | no request outstanding; issue when not flushing and the queue has room
// WAIT   | read of req_pc outstanding; a response is enqueued unless flushed
// SQUASH | read outstanding but flushed; wait for the response and drop it
module ifetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic [31:0]    pc_i,
  output logic           load_pc,
  ifetch_queue_if.master imem,
  input  logic           deq,
  output logic           out_valid,
  output logic [31:0]    instruction,
  output logic [31:0]    out_pc,
  output logic [31:0]    out_pc_plus4
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, SQUASH} state_t;

  state_t        state, state_next;
  logic [31:0]   req_pc, req_pc_next;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_next;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   word_mem [DEPTH];
  logic          enq, pop;

  assign enq        = (state == WAIT) && imem.imem_resp && !flush;
  assign pop        = deq && (count != '0);
  assign count_next = count + CW'(enq) - CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      req_pc <= '0;
    end else begin
      state  <= state_next;
      req_pc <= req_pc_next;
    end
  end

  // Back-to-back fetch only while the post-response occupancy still leaves room,
  // so a single outstanding read can never overflow the queue.
  always_comb begin
    state_next  = state;
    req_pc_next = req_pc;
    case (state)
      IDLE: begin
        if (!flush && (count < FULL)) begin
          state_next  = WAIT;
          req_pc_next = pc_i;
        end
      end
      WAIT: begin
        if (imem.imem_resp) begin
          if (flush)
            state_next = IDLE;
          else if (count_next < FULL)
            req_pc_next = req_pc + 32'd4;
          else
            state_next = IDLE;
        end else if (flush) begin
          state_next = SQUASH;
        end
      end
      SQUASH: begin
        if (imem.imem_resp)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)
        tail <= tail + PW'(1);
      if (pop)
        head <= head + PW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail]   <= req_pc;
      word_mem[tail] <= imem.imem_rdata;
    end
  end

  // On flush the fetch-stage mux presents the redirect target, so load_pc follows flush.
  assign load_pc           = !rst && (enq || flush);
  assign imem.imem_read    = (state != IDLE);
  assign imem.imem_address = req_pc;
  assign out_valid         = (count != '0);
  assign instruction       = word_mem[head];
  assign out_pc            = pc_mem[head];
  assign out_pc_plus4      = pc_mem[head] + 32'd4;
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus randomized traffic checked against a
// queue-based model of the fetch stream (next PC, redirect targets, squashed reads).
module tb_ifetch_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        deq = 1'b0;
  logic [31:0] pc_i = '0;
  logic        load_pc, out_valid;
  logic [31:0] instruction, out_pc, out_pc_plus4;

  ifetch_queue_if bus();

  ifetch_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .pc_i         (pc_i),
    .load_pc      (load_pc),
    .imem         (bus),
    .deq          (deq),
    .out_valid    (out_valid),
    .instruction  (instruction),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4)
  );

  always #5 clk = ~clk;

  // model state
  entry_t      q[$];
  logic [31:0] next_pc, redirect, req_addr;
  bit          in_req, poisoned, rdata_fixed;
  int          wait_left;
  // per-cycle expectations
  bit          acc, popped, room, exp_load_pc, exp_valid, cur_in_req;
  entry_t      exp_head;
  logic [31:0] exp_fetch, cur_req_addr;
  int          passed = 0, total = 0;

  task automatic apply_reset(input logic [31:0] start);
    rst = 1'b1;
    flush = 1'b0;
    deq = 1'b0;
    bus.imem_resp = 1'b0;
    repeat (2) @(posedge clk);
    q.delete();
    in_req = 1'b0;
    poisoned = 1'b0;
    next_pc = start;
    pc_i = start;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: act as memory and environment, then at the falling edge derive what the
  // DUT must show this cycle and advance the model past the coming rising edge.
  task automatic drive_cycle(input bit f, input bit d, input int lat);
    @(posedge clk);
    #1;
    bus.imem_resp = 1'b0;
    if (bus.imem_read === 1'b1) begin
      if (!in_req) begin
        in_req = 1'b1;
        poisoned = 1'b0;
        req_addr = bus.imem_address;
        wait_left = (lat < 0) ? int'($urandom_range(3)) : lat;
      end
      if (wait_left == 0) begin
        bus.imem_resp = 1'b1;
        bus.imem_rdata = rdata_fixed ? 32'h0000_0013 : $urandom;
      end else begin
        wait_left--;
      end
    end
    flush = f;
    deq = d;
    cur_in_req = in_req;
    cur_req_addr = req_addr;
    @(negedge clk);
    if (f && in_req) poisoned = 1'b1;
    acc = bus.imem_resp && !poisoned;
    exp_load_pc = f || acc;
    exp_valid = (q.size() != 0);
    if (exp_valid) exp_head = q[0];
    exp_fetch = next_pc;
    popped = d && exp_valid && !f;
    if (popped) void'(q.pop_front());
    room = (q.size() < DEPTH);
    if (f) begin
      q.delete();
      next_pc = redirect;
    end else if (acc) begin
      q.push_back(entry_t'({next_pc, bus.imem_rdata}));
      next_pc = next_pc + 32'd4;
    end
    if (bus.imem_resp) in_req = 1'b0;
    pc_i = next_pc;
  endtask

  task automatic test_reset;
    #1;
    total++; if (bus.imem_read !== 1'b0) $display("FAIL reset_read: got %b expected 0", bus.imem_read); else passed++;
    total++; if (load_pc !== 1'b0) $display("FAIL reset_load_pc: got %b expected 0", load_pc); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_stream;
    int n_acc = 0;
    int n_pop = 0;
    rdata_fixed = 1'b1;
    apply_reset(32'h60);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 1'b1, 0);
      total++; if (load_pc !== exp_load_pc) $display("FAIL stream_load_pc: got %b expected %b", load_pc, exp_load_pc); else passed++;
      if (acc) begin
        total++;
        if (bus.imem_address !== 32'h60 + 32'(4 * n_acc))
          $display("FAIL stream_addr: got %h expected %h", bus.imem_address, 32'h60 + 32'(4 * n_acc));
        else passed++;
        n_acc++;
      end
      if (popped) begin
        total++;
        if (out_pc !== 32'h60 + 32'(4 * n_pop) || instruction !== 32'h0000_0013)
          $display("FAIL stream_head: got pc %h word %h expected pc %h word 00000013", out_pc, instruction, 32'h60 + 32'(4 * n_pop));
        else passed++;
        if (n_pop == 0) begin
          total++; if (out_pc_plus4 !== 32'h64) $display("FAIL stream_pc_plus4: got %h expected 00000064", out_pc_plus4); else passed++;
        end
        n_pop++;
      end
    end
    total++; if (n_acc != 6) $display("FAIL stream_throughput: got %0d responses expected 6", n_acc); else passed++;
    rdata_fixed = 1'b0;
  endtask

  task automatic test_fill;
    int n_acc = 0;
    apply_reset(32'h60);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'b0, 0);
      if (acc) n_acc++;
      total++; if (load_pc !== exp_load_pc) $display("FAIL fill_load_pc: got %b expected %b", load_pc, exp_load_pc); else passed++;
    end
    total++; if (n_acc != 4) $display("FAIL fill_accepts: got %0d expected 4", n_acc); else passed++;
    total++; if (bus.imem_read !== 1'b0) $display("FAIL fill_stall_read: got %b expected 0", bus.imem_read); else passed++;
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h60) $display("FAIL fill_head: got valid %b pc %h expected 1 00000060", out_valid, out_pc); else passed++;
    drive_cycle(1'b0, 1'b1, 0);
    drive_cycle(1'b0, 1'b0, 0);
    total++; if (bus.imem_read !== 1'b0) $display("FAIL fill_early_issue: got %b expected 0", bus.imem_read); else passed++;
    drive_cycle(1'b0, 1'b0, 0);
    total++;
    if (bus.imem_read !== 1'b1 || bus.imem_address !== 32'h70 || load_pc !== 1'b1)
      $display("FAIL fill_refill: got read %b addr %h load_pc %b expected 1 00000070 1", bus.imem_read, bus.imem_address, load_pc);
    else passed++;
  endtask

  task automatic test_flush_mid;
    bit saw_resp = 1'b0;
    bit saw_new = 1'b0;
    apply_reset(32'h80);
    redirect = 32'h200;
    drive_cycle(1'b0, 1'b0, 5);
    total++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 32'h80) $display("FAIL flushmid_issue: got read %b addr %h expected 1 00000080", bus.imem_read, bus.imem_address); else passed++;
    drive_cycle(1'b1, 1'b0, 5);
    total++; if (load_pc !== 1'b1) $display("FAIL flushmid_load_pc_flush: got %b expected 1", load_pc); else passed++;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b0, 1'b0, 2);
      total++; if (load_pc !== exp_load_pc) $display("FAIL flushmid_load_pc: got %b expected %b", load_pc, exp_load_pc); else passed++;
      if (!saw_resp) begin
        total++;
        if (bus.imem_read !== 1'b1 || bus.imem_address !== 32'h80 || out_valid !== 1'b0)
          $display("FAIL flushmid_squash: got read %b addr %h valid %b expected 1 00000080 0", bus.imem_read, bus.imem_address, out_valid);
        else passed++;
        if (bus.imem_resp === 1'b1) saw_resp = 1'b1;
      end else if (acc && !saw_new) begin
        saw_new = 1'b1;
        total++; if (bus.imem_address !== 32'h200) $display("FAIL flushmid_new_addr: got %h expected 00000200", bus.imem_address); else passed++;
      end
    end
    total++; if (!saw_resp || !saw_new) $display("FAIL flushmid_progress: got resp %b new %b expected 1 1", saw_resp, saw_new); else passed++;
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h200) $display("FAIL flushmid_head: got valid %b pc %h expected 1 00000200", out_valid, out_pc); else passed++;
  endtask

  task automatic test_flush_coincident;
    apply_reset(32'h300);
    redirect = 32'h400;
    drive_cycle(1'b0, 1'b0, 0);
    drive_cycle(1'b0, 1'b0, 0);
    drive_cycle(1'b1, 1'b1, 0);
    total++;
    if (out_valid !== 1'b1 || load_pc !== 1'b1 || bus.imem_resp !== 1'b1)
      $display("FAIL coinc_setup: got valid %b load_pc %b resp %b expected 1 1 1", out_valid, load_pc, bus.imem_resp);
    else passed++;
    drive_cycle(1'b0, 1'b0, 1);
    total++; if (out_valid !== 1'b0) $display("FAIL coinc_cleared: got %b expected 0", out_valid); else passed++;
    total++; if (bus.imem_read !== 1'b0) $display("FAIL coinc_idle: got %b expected 0", bus.imem_read); else passed++;
    drive_cycle(1'b0, 1'b0, 1);
    total++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 32'h400) $display("FAIL coinc_reissue: got read %b addr %h expected 1 00000400", bus.imem_read, bus.imem_address); else passed++;
    drive_cycle(1'b0, 1'b0, 1);
    drive_cycle(1'b0, 1'b0, 1);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h400) $display("FAIL coinc_head: got valid %b pc %h expected 1 00000400", out_valid, out_pc); else passed++;
  endtask

  task automatic test_async_reset;
    apply_reset(32'h500);
    drive_cycle(1'b0, 1'b0, 0);
    drive_cycle(1'b0, 1'b0, 0);
    drive_cycle(1'b0, 1'b0, 3);
    total++; if (out_valid !== 1'b1 || bus.imem_read !== 1'b1) $display("FAIL areset_setup: got valid %b read %b expected 1 1", out_valid, bus.imem_read); else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.imem_read !== 1'b0 || out_valid !== 1'b0 || load_pc !== 1'b0)
      $display("FAIL areset_outputs: got read %b valid %b load_pc %b expected 0 0 0", bus.imem_read, out_valid, load_pc);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    q.delete();
    in_req = 1'b0;
    next_pc = 32'h600;
    pc_i = 32'h600;
    bus.imem_resp = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    rst = 1'b0;
    #1;
    total++; if (load_pc !== 1'b0) $display("FAIL areset_stale_load_pc: got %b expected 0", load_pc); else passed++;
    @(posedge clk);
    #1 bus.imem_resp = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL areset_stale_enq: got %b expected 0", out_valid); else passed++;
    total++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 32'h600) $display("FAIL areset_reissue: got read %b addr %h expected 1 00000600", bus.imem_read, bus.imem_address); else passed++;
  endtask

  task automatic test_random(input int cycles, input int flush_pct);
    int n_acc = 0;
    bit f;
    apply_reset($urandom & 32'hFFFF_FFFC);
    for (int i = 0; i < cycles; i++) begin
      f = ($urandom_range(99) < flush_pct);
      if (f) redirect = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      drive_cycle(f, 1'($urandom_range(1)), -1);
      total++; if (load_pc !== exp_load_pc) $display("FAIL rand_load_pc: cycle %0d got %b expected %b", i, load_pc, exp_load_pc); else passed++;
      total++; if (out_valid !== exp_valid) $display("FAIL rand_valid: cycle %0d got %b expected %b", i, out_valid, exp_valid); else passed++;
      if (exp_valid) begin
        total++;
        if ({out_pc, instruction, out_pc_plus4} !== {exp_head.pc, exp_head.word, exp_head.pc + 32'd4})
          $display("FAIL rand_head: cycle %0d got %h %h %h expected %h %h %h", i, out_pc, instruction, out_pc_plus4,
                   exp_head.pc, exp_head.word, exp_head.pc + 32'd4);
        else passed++;
      end
      if (cur_in_req) begin
        total++; if (bus.imem_address !== cur_req_addr) $display("FAIL rand_addr_stable: cycle %0d got %h expected %h", i, bus.imem_address, cur_req_addr); else passed++;
      end
      if (acc) begin
        n_acc++;
        total++; if (bus.imem_address !== exp_fetch) $display("FAIL rand_fetch_addr: cycle %0d got %h expected %h", i, bus.imem_address, exp_fetch); else passed++;
        total++; if (!room) $display("FAIL rand_overflow: cycle %0d got accept with %0d entries expected fewer than %0d", i, q.size(), DEPTH); else passed++;
      end
    end
    total++; if (n_acc < 10) $display("FAIL rand_progress: got %0d responses expected at least 10", n_acc); else passed++;
  endtask

  initial begin
    bus.imem_resp = 1'b0;
    bus.imem_rdata = '0;
    rdata_fixed = 1'b0;
    redirect = '0;
    test_reset();
    test_stream();
    test_fill();
    test_flush_mid();
    test_flush_coincident();
    test_async_reset();
    test_random(80, 0);
    test_random(600, 6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
